// File: rtl/vx_stream_demux.sv
// vx_stream_demux: steers each input beat to one output of its slice by sel_in,
// with an optional per-output pipe register or skid buffer.
module vx_stream_demux #(
  parameter int NUM_INPUTS  = 1,
  parameter int NUM_OUTPUTS = 1,
  parameter int DATAW       = 1,
  parameter int OUT_BUF     = 0,
  parameter int NUM_REQS    = (NUM_OUTPUTS + NUM_INPUTS - 1) / NUM_INPUTS,
  parameter int NUM_REQS_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_INPUTS-1:0]                  valid_in,
  input  logic [NUM_INPUTS-1:0][DATAW-1:0]       data_in,
  input  logic [NUM_INPUTS-1:0][NUM_REQS_W-1:0]  sel_in,
  output logic [NUM_INPUTS-1:0]                  ready_in,
  output logic [NUM_OUTPUTS-1:0]                 valid_out,
  output logic [NUM_OUTPUTS-1:0][DATAW-1:0]      data_out,
  input  logic [NUM_OUTPUTS-1:0]                 ready_out,
  output logic                                   sel_err
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  logic [NUM_OUTPUTS-1:0] buf_valid, buf_ready;
  logic [NUM_INPUTS-1:0] bad_sel;
  genvar i, o;
  for (i = 0; i < NUM_INPUTS; i++) begin : g_in
    localparam int BASE = i * NUM_REQS;
    localparam int REM = NUM_OUTPUTS - BASE;
    localparam int S = (REM > NUM_REQS) ? NUM_REQS : ((REM > 0) ? REM : 0);
    logic ok, rdy;
    // a single-output slice ignores sel_in entirely
    assign ok = (NUM_REQS == 1) || (int'(sel_in[i]) < S);
    assign bad_sel[i] = valid_in[i] && !ok;
    always_comb begin
      rdy = !ok;
      for (int k = 0; k < S; k++)
        if (ok && (NUM_REQS == 1 || int'(sel_in[i]) == k)) rdy = buf_ready[BASE + k];
    end
    assign ready_in[i] = rdy;
  end
  for (o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    localparam int IN = o / NUM_REQS;
    localparam int K = o % NUM_REQS;
    assign buf_valid[o] = valid_in[IN] && (NUM_REQS == 1 || int'(sel_in[IN]) == K);
    if (OUT_BUF == 0) begin : g_pass
      assign valid_out[o] = buf_valid[o];
      assign data_out[o]  = data_in[IN];
      assign buf_ready[o] = ready_out[o];
    end else if (OUT_BUF == 1) begin : g_pipe
      logic v;
      logic [DATAW-1:0] d;
      always_ff @(posedge clk) begin
        if (!reset) begin
          v <= 1'b0;
          d <= '0;
        end else if (buf_ready[o]) begin
          v <= buf_valid[o];
          if (buf_valid[o]) d <= data_in[IN];
        end
      end
      assign buf_ready[o] = !v || ready_out[o];
      assign valid_out[o] = v;
      assign data_out[o]  = d;
    end else begin : g_skid
      state_t state, state_n;
      logic [DATAW-1:0] main_q, skid_q;
      logic push, pop;
      assign push = buf_valid[o] && state != FULL;
      assign pop  = state != EMPTY && ready_out[o];
      always_comb begin
        state_n = state;
        state_n = (state == EMPTY) ? (push ? ONE : EMPTY)
                : (state == ONE)   ? ((push && !pop) ? FULL : ((pop && !push) ? EMPTY : ONE))
                :                    (pop ? ONE : FULL);
      end
      always_ff @(posedge clk) begin
        if (!reset) begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end else begin
          state <= state_n;
          if (state == FULL) begin
            if (pop) main_q <= skid_q;
          end else if (push && (state == EMPTY || pop)) main_q <= data_in[IN];
          else if (push) skid_q <= data_in[IN];
        end
      end
      // ready comes straight from the FULL state bit, never from ready_out
      assign buf_ready[o] = !state[1];
      assign valid_out[o] = state[0];
      assign data_out[o]  = main_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) sel_err <= 1'b0;
    else if (|bad_sel) sel_err <= 1'b1;
  end
endmodule

// File: tb/tb_vx_stream_demux.sv
// tb_vx_stream_demux: three demux configurations driven randomly and checked
// against per-output FIFO queues.
module tb_vx_stream_demux;
  localparam int NI [3] = '{1, 2, 2};
  localparam int NO [3] = '{4, 3, 2};
  localparam int NR [3] = '{4, 2, 1};
  localparam int OB [3] = '{1, 2, 0};
  localparam int SW [3] = '{2, 1, 1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] vin [3];
  logic [7:0] din [3][2];
  logic [1:0] sin [3][2];
  logic [3:0] rout [3];
  logic [1:0] rin [3];
  logic [3:0] vout [3];
  logic [7:0] dout [3][4];
  logic err [3];
  logic [0:0] v0, r0;
  logic [0:0][7:0] d0;
  logic [0:0][1:0] s0;
  logic [3:0] vo0, ro0;
  logic [3:0][7:0] do0;
  logic e0;
  logic [1:0] v1, r1;
  logic [1:0][7:0] d1;
  logic [1:0][0:0] s1;
  logic [2:0] vo1, ro1;
  logic [2:0][7:0] do1;
  logic e1;
  logic [1:0] v2, r2;
  logic [1:0][7:0] d2;
  logic [1:0][0:0] s2;
  logic [1:0] vo2, ro2;
  logic [1:0][7:0] do2;
  logic e2;
  assign v0 = vin[0][0:0];
  assign d0 = din[0][0];
  assign s0 = sin[0][0];
  assign ro0 = rout[0];
  assign v1 = vin[1];
  assign d1 = {din[1][1], din[1][0]};
  assign s1 = {sin[1][1][0], sin[1][0][0]};
  assign ro1 = rout[1][2:0];
  assign v2 = vin[2];
  assign d2 = {din[2][1], din[2][0]};
  assign s2 = {sin[2][1][0], sin[2][0][0]};
  assign ro2 = rout[2][1:0];
  always_comb begin
    rin[0] = {1'b0, r0};
    rin[1] = r1;
    rin[2] = r2;
    vout[0] = vo0;
    vout[1] = {1'b0, vo1};
    vout[2] = {2'b0, vo2};
    dout[0] = '{do0[0], do0[1], do0[2], do0[3]};
    dout[1] = '{do1[0], do1[1], do1[2], 8'h0};
    dout[2] = '{do2[0], do2[1], 8'h0, 8'h0};
    err[0] = e0;
    err[1] = e1;
    err[2] = e2;
  end
  vx_stream_demux #(.NUM_INPUTS(1), .NUM_OUTPUTS(4), .DATAW(8), .OUT_BUF(1)) u0 (
    .clk(clk), .reset(rst_n), .valid_in(v0), .data_in(d0), .sel_in(s0), .ready_in(r0),
    .valid_out(vo0), .data_out(do0), .ready_out(ro0), .sel_err(e0));
  vx_stream_demux #(.NUM_INPUTS(2), .NUM_OUTPUTS(3), .DATAW(8), .OUT_BUF(2)) u1 (
    .clk(clk), .reset(rst_n), .valid_in(v1), .data_in(d1), .sel_in(s1), .ready_in(r1),
    .valid_out(vo1), .data_out(do1), .ready_out(ro1), .sel_err(e1));
  vx_stream_demux #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .DATAW(8), .OUT_BUF(0)) u2 (
    .clk(clk), .reset(rst_n), .valid_in(v2), .data_in(d2), .sel_in(s2), .ready_in(r2),
    .valid_out(vo2), .data_out(do2), .ready_out(ro2), .sel_err(e2));
  int checks = 0;
  int failures = 0;
  logic [7:0] q [3][4][$];
  logic e_m [3];
  bit just_reset;
  function automatic string tag(input string n, input int k, input int x);
    return $sformatf("%s%0d_%0d", n, k, x);
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      e_m[k] = 1'b0;
      for (int o = 0; o < 4; o++) q[k][o].delete();
    end
  endtask
  task automatic step(input int k);
    int t [2];
    bit ok [2];
    bit er [2];
    for (int i = 0; i < NI[k]; i++) begin
      int s;
      int sz;
      s = (NR[k] == 1) ? 0 : int'(sin[k][i]);
      sz = NO[k] - i * NR[k];
      if (sz > NR[k]) sz = NR[k];
      ok[i] = s < sz;
      t[i] = i * NR[k] + s;
      if (!ok[i]) er[i] = 1'b1;
      else if (OB[k] == 0) er[i] = rout[k][t[i]];
      else if (OB[k] == 1) er[i] = q[k][t[i]].size() == 0 || rout[k][t[i]];
      else er[i] = q[k][t[i]].size() < 2;
      check(tag("rdy", k, i), 32'(rin[k][i]), 32'(er[i]));
    end
    for (int o = 0; o < NO[k]; o++) begin
      int i;
      bit ev;
      i = o / NR[k];
      ev = (OB[k] == 0) ? (vin[k][i] && ok[i] && t[i] == o) : (q[k][o].size() > 0);
      check(tag("vld", k, o), 32'(vout[k][o]), 32'(ev));
      if (ev) begin
        if (OB[k] == 0) check(tag("dat", k, o), 32'(dout[k][o]), 32'(din[k][i]));
        else check(tag("dat", k, o), 32'(dout[k][o]), 32'(q[k][o][0]));
      end
    end
    check(tag("err", k, 0), 32'(err[k]), 32'(e_m[k]));
    if (!rst_n) return;
    for (int o = 0; o < NO[k]; o++)
      if (q[k][o].size() > 0 && rout[k][o]) void'(q[k][o].pop_front());
    for (int i = 0; i < NI[k]; i++)
      if (vin[k][i]) begin
        if (!ok[i]) e_m[k] = 1'b1;
        else if (er[i] && OB[k] != 0) q[k][t[i]].push_back(din[k][i]);
      end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      vin[k] = '0;
      rout[k] = 4'hF;
      for (int i = 0; i < 2; i++) begin
        din[k][i] = '0;
        sin[k][i] = '0;
      end
    end
    clear_model();
    repeat (3) @(posedge clk);
    just_reset = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      int mode;
      @(negedge clk);
      rst_n = c < 20 || $urandom_range(0, 99) != 0;
      mode = (c / 150) % 3;
      for (int k = 0; k < 3; k++) begin
        vin[k] = 2'($urandom_range(0, 3));
        for (int i = 0; i < 2; i++) begin
          din[k][i] = 8'($urandom);
          sin[k][i] = 2'($urandom_range(0, (1 << SW[k]) - 1));
        end
        rout[k] = (mode == 0) ? 4'hF : (mode == 1) ? 4'($urandom) : 4'($urandom) & 4'($urandom) & 4'($urandom);
      end
      #1;
      if (just_reset)
        for (int k = 0; k < 2; k++)
          for (int o = 0; o < NO[k]; o++) check(tag("rstdat", k, o), 32'(dout[k][o]), 32'h0);
      for (int k = 0; k < 3; k++) step(k);
      just_reset = !rst_n;
      if (!rst_n) clear_model();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
